// File: rtl/conv_cmd_pkg.sv
// Shared definitions for the convolution command sequencer: instruction field
// positions and the sequencing FSM state encoding.
package conv_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  // Compute instruction word {Reg_7,Reg_6,Reg_5,Reg_4}
  localparam int ZP1_MSB    = 127, ZP1_LSB    = 120;
  localparam int ZP3_MSB    = 119, ZP3_LSB    = 112;
  localparam int WDDR_BIT   = 97;
  localparam int RDDR_BIT   = 96;
  localparam int ENCIN_BIT  = 63;
  localparam int PAD_BIT    = 62;
  localparam int STRIDE_BIT = 61;
  localparam int ZNUM_MSB   = 60,  ZNUM_LSB   = 58;
  localparam int LEAKY_BIT  = 57;
  localparam int ROWIN_MSB  = 42,  ROWIN_LSB  = 32;
  localparam int CHIN_MSB   = 31,  CHIN_LSB   = 22;
  localparam int ROWOUT_MSB = 21,  ROWOUT_LSB = 11;
  localparam int CHOUT_MSB  = 9,   CHOUT_LSB  = 0;

  // Para instruction word {Reg_4,Reg_5}
  localparam int WNUM_MSB   = 63,  WNUM_LSB   = 48;
  localparam int BNUM_MSB   = 47,  BNUM_LSB   = 40;
  localparam int C11P_BIT   = 33;
  localparam int C11_BIT    = 32;
  localparam int WCIN_MSB   = 31,  WCIN_LSB   = 22;
  localparam int WCOUT_MSB  = 9,   WCOUT_LSB  = 0;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for compute instructions; a push while full is dropped,
// and full is evaluated before any same-cycle pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int W     = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_cmd_sequencer.sv
// Instruction front-end for the convolution pipeline: queues compute commands,
// holds a para command, decodes fields and sequences each layer to completion.
module conv_cmd_sequencer
  import conv_cmd_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_type,
  input  logic [127:0]     cmd_data,
  output logic             next_reg,
  output logic             start_cu,
  output logic             start_pa,
  input  logic             conv_complete,
  input  logic             stride_complete,
  output logic             layer_done,
  output logic             busy,
  output logic [CNT_W-1:0] queue_count,
  output logic             err,
  output logic [7:0]       zero_point1,
  output logic [7:0]       zero_point3,
  output logic             write_ddr,
  output logic             read_ddr,
  output logic             en_cin_sel,
  output logic             padding,
  output logic             stride,
  output logic             leaky,
  output logic [2:0]       zero_num,
  output logic [10:0]      row_num_in,
  output logic [10:0]      row_num_out,
  output logic [9:0]       ch_in_num,
  output logic [9:0]       ch_out_num,
  output logic [15:0]      weight_num,
  output logic [7:0]       bias_num,
  output logic             conv11,
  output logic             conv11_par,
  output logic [9:0]       w_ch_in,
  output logic [9:0]       w_ch_out,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             g33_valid,
  output logic             g11_valid,
  input  logic             g33_ready,
  input  logic             g11_ready
);

  state_t               state, state_nxt;
  logic [127:0]         head;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, para_push;
  logic [63:0]          para_slot;
  logic                 para_pending, para_used;
  logic                 cc_seen, sc_seen, both_done;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_max, wd_expired;
  logic                 unused_bits;

  // Para is locked only while a layer may still be consuming the slot.
  assign cmd_ready = cmd_type ? ~(para_pending & (state != ST_IDLE)) : ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready & ~cmd_type;
  assign para_push = cmd_valid & cmd_ready & cmd_type;
  assign fifo_pop  = (state == ST_DONE);
  assign both_done = (cc_seen | conv_complete) & (sc_seen | stride_complete);
  assign wd_max    = &wd_cnt;

  cmd_fifo #(.DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W), .W(128)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cmd_data),
    .dout  (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (both_done || wd_max) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    next_reg   = (state == ST_LOAD);
    start_cu   = (state == ST_START);
    start_pa   = (state == ST_START) & para_used;
    layer_done = (state == ST_DONE) & ~wd_expired;
    busy       = (state != ST_IDLE);
    g11_valid  = 1'b0;
    g33_valid  = 1'b0;
    s_ready    = 1'b0;
    if (state == ST_RUN) begin
      g11_valid = conv11 & s_valid;
      g33_valid = ~conv11 & s_valid;
      s_ready   = conv11 ? g11_ready : g33_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      para_slot    <= '0;
      para_pending <= 1'b0;
      para_used    <= 1'b0;
      cc_seen      <= 1'b0;
      sc_seen      <= 1'b0;
      wd_cnt       <= '0;
      wd_expired   <= 1'b0;
      err          <= 1'b0;
      zero_point1  <= '0;
      zero_point3  <= '0;
      write_ddr    <= 1'b0;
      read_ddr     <= 1'b0;
      en_cin_sel   <= 1'b0;
      padding      <= 1'b0;
      stride       <= 1'b0;
      zero_num     <= '0;
      leaky        <= 1'b0;
      row_num_in   <= '0;
      ch_in_num    <= '0;
      row_num_out  <= '0;
      ch_out_num   <= '0;
      weight_num   <= '0;
      bias_num     <= '0;
      conv11_par   <= 1'b0;
      conv11       <= 1'b0;
      w_ch_in      <= '0;
      w_ch_out     <= '0;
    end else begin
      if (para_push) begin
        para_slot    <= cmd_data[63:0];
        para_pending <= 1'b1;
      end else if (state == ST_START && para_used) begin
        para_pending <= 1'b0;
      end

      if (state == ST_LOAD) begin
        para_used   <= para_pending;
        zero_point1 <= head[ZP1_MSB:ZP1_LSB];
        zero_point3 <= head[ZP3_MSB:ZP3_LSB];
        write_ddr   <= head[WDDR_BIT];
        read_ddr    <= head[RDDR_BIT];
        en_cin_sel  <= head[ENCIN_BIT];
        padding     <= head[PAD_BIT];
        stride      <= head[STRIDE_BIT];
        zero_num    <= head[ZNUM_MSB:ZNUM_LSB];
        leaky       <= head[LEAKY_BIT];
        row_num_in  <= head[ROWIN_MSB:ROWIN_LSB];
        ch_in_num   <= head[CHIN_MSB:CHIN_LSB];
        row_num_out <= head[ROWOUT_MSB:ROWOUT_LSB];
        ch_out_num  <= head[CHOUT_MSB:CHOUT_LSB];
        if (para_pending) begin
          weight_num <= para_slot[WNUM_MSB:WNUM_LSB];
          bias_num   <= para_slot[BNUM_MSB:BNUM_LSB];
          conv11_par <= para_slot[C11P_BIT];
          conv11     <= para_slot[C11_BIT];
          w_ch_in    <= para_slot[WCIN_MSB:WCIN_LSB];
          w_ch_out   <= para_slot[WCOUT_MSB:WCOUT_LSB];
        end
      end

      if (state == ST_RUN) begin
        if (conv_complete)   cc_seen <= 1'b1;
        if (stride_complete) sc_seen <= 1'b1;
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
        // Completion wins if it lands on the same cycle as the timeout.
        if (wd_max && !both_done) begin
          wd_expired <= 1'b1;
          err        <= 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end

      if (state == ST_DONE) begin
        cc_seen    <= 1'b0;
        sc_seen    <= 1'b0;
        wd_expired <= 1'b0;
      end

      if ((conv_complete || stride_complete) && state != ST_RUN) err <= 1'b1;
    end
  end

  assign unused_bits = ^{head[111:98], head[95:64], head[56:43], head[10],
                         para_slot[39:34], para_slot[21:10]};

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// Directed bench for conv_cmd_sequencer: para/compute loading, queue full,
// completion ordering, stream steering, error flag, reset and watchdog.
module tb_conv_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_type;
  logic [127:0] cmd_data;
  logic         next_reg, start_cu, start_pa;
  logic         conv_complete, stride_complete;
  logic         layer_done, busy, err;
  logic [2:0]   queue_count;
  logic [7:0]   zero_point1, zero_point3;
  logic         write_ddr, read_ddr, en_cin_sel, padding, stride, leaky;
  logic [2:0]   zero_num;
  logic [10:0]  row_num_in, row_num_out;
  logic [9:0]   ch_in_num, ch_out_num;
  logic [15:0]  weight_num;
  logic [7:0]   bias_num;
  logic         conv11, conv11_par;
  logic [9:0]   w_ch_in, w_ch_out;
  logic         s_valid, s_ready, g33_valid, g11_valid, g33_ready, g11_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_cmd_sequencer #(.QUEUE_DEPTH(4), .CNT_W(3), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
    .next_reg(next_reg), .start_cu(start_cu), .start_pa(start_pa),
    .conv_complete(conv_complete), .stride_complete(stride_complete),
    .layer_done(layer_done), .busy(busy), .queue_count(queue_count), .err(err),
    .zero_point1(zero_point1), .zero_point3(zero_point3),
    .write_ddr(write_ddr), .read_ddr(read_ddr), .en_cin_sel(en_cin_sel),
    .padding(padding), .stride(stride), .leaky(leaky), .zero_num(zero_num),
    .row_num_in(row_num_in), .row_num_out(row_num_out),
    .ch_in_num(ch_in_num), .ch_out_num(ch_out_num),
    .weight_num(weight_num), .bias_num(bias_num),
    .conv11(conv11), .conv11_par(conv11_par), .w_ch_in(w_ch_in), .w_ch_out(w_ch_out),
    .s_valid(s_valid), .s_ready(s_ready), .g33_valid(g33_valid), .g11_valid(g11_valid),
    .g33_ready(g33_ready), .g11_ready(g11_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle handshake; the command must be accepted on the next edge.
  task automatic push(input logic t, input logic [127:0] d);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    #1;
    check("push_ready", cmd_ready, 1);
    cycle();
    cmd_valid = 1'b0;
    cmd_type  = 1'b0;
  endtask

  task automatic complete_both();
    conv_complete   = 1'b1;
    stride_complete = 1'b1;
    cycle();
    conv_complete   = 1'b0;
    stride_complete = 1'b0;
  endtask

  function automatic logic [127:0] mk_cmp(input logic [10:0] rin, input logic [9:0] cin,
                                          input logic strd, input logic [7:0] zp1);
    logic [127:0] w;
    w = '0;
    w[127:120] = zp1;
    w[61]      = strd;
    w[42:32]   = rin;
    w[31:22]   = cin;
    return w;
  endfunction

  function automatic logic [127:0] mk_para(input logic [15:0] wn, input logic [7:0] bn,
                                           input logic c11);
    logic [127:0] w;
    w = '0;
    w[63:48] = wn;
    w[47:40] = bn;
    w[32]    = c11;
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_type = 1'b0; cmd_data = '0;
    conv_complete = 1'b0; stride_complete = 1'b0;
    s_valid = 1'b0; g33_ready = 1'b0; g11_ready = 1'b0;

    // Reset state
    cycle(); cycle();
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", queue_count, 0);
    check("rst_err", err, 0);
    check("rst_next_reg", next_reg, 0);
    check("rst_row_in", row_num_in, 0);
    check("rst_weight", weight_num, 0);
    rst = 1'b1;
    cycle();

    // Para + compute: next_reg one cycle after the compute push
    push(1'b1, mk_para(16'h0120, 8'h07, 1'b0));
    push(1'b0, mk_cmp(11'd26, 10'd32, 1'b1, 8'h5A));
    check("t1_idle_busy", busy, 0);
    cycle();
    check("t1_next_reg", next_reg, 1);
    check("t1_busy", busy, 1);
    cycle();
    check("t1_start_cu", start_cu, 1);
    check("t1_start_pa", start_pa, 1);
    check("t1_next_reg_off", next_reg, 0);
    check("t1_row_in", row_num_in, 26);
    check("t1_ch_in", ch_in_num, 32);
    check("t1_stride", stride, 1);
    check("t1_zp1", zero_point1, 8'h5A);
    check("t1_weight", weight_num, 16'h0120);
    check("t1_bias", bias_num, 8'h07);
    cycle();
    check("t1_start_cu_off", start_cu, 0);
    check("t1_count_run", queue_count, 1);

    // conv_complete 10 cycles before stride_complete
    conv_complete = 1'b1;
    cycle();
    conv_complete = 1'b0;
    repeat (9) cycle();
    check("t3_wait_busy", busy, 1);
    check("t3_wait_done", layer_done, 0);
    stride_complete = 1'b1;
    cycle();
    stride_complete = 1'b0;
    check("t3_done", layer_done, 1);
    check("t3_done_count", queue_count, 1);
    cycle();
    check("t3_done_off", layer_done, 0);
    check("t3_count_pop", queue_count, 0);
    check("t3_idle", busy, 0);
    check("t3_hold_row", row_num_in, 26);

    // Both completions in the same cycle; para fields persist, no start_pa
    push(1'b0, mk_cmp(11'd100, 10'd3, 1'b0, 8'h11));
    cycle();
    check("t3b_next_reg", next_reg, 1);
    cycle();
    check("t3b_start_cu", start_cu, 1);
    check("t3b_start_pa", start_pa, 0);
    check("t3b_row_in", row_num_in, 100);
    check("t3b_weight_keep", weight_num, 16'h0120);
    cycle();
    complete_both();
    check("t3b_done", layer_done, 1);
    cycle();
    check("t3b_done_off", layer_done, 0);
    check("t3b_count", queue_count, 0);
    check("t3b_err", err, 0);

    // 1x1 steering
    push(1'b1, mk_para(16'h0044, 8'h02, 1'b1));
    s_valid = 1'b1; g11_ready = 1'b1;
    #1;
    check("t4_idle_sready", s_ready, 0);
    check("t4_idle_g11v", g11_valid, 0);
    push(1'b0, mk_cmp(11'd13, 10'd8, 1'b0, 8'h00));
    cycle();
    cmd_type = 1'b1;
    #1;
    check("t4_para_locked", cmd_ready, 0);
    cmd_type = 1'b0;
    cycle();
    check("t4_start_pa", start_pa, 1);
    check("t4_conv11", conv11, 1);
    check("t4_start_sready", s_ready, 0);
    cycle();
    check("t4_g11v", g11_valid, 1);
    check("t4_g33v", g33_valid, 0);
    check("t4_sready_hi", s_ready, 1);
    g11_ready = 1'b0; g33_ready = 1'b1;
    #1;
    check("t4_sready_lo", s_ready, 0);
    g11_ready = 1'b1; g33_ready = 1'b0;
    #1;
    check("t4_sready_hi2", s_ready, 1);
    complete_both();
    check("t4_done_sready", s_ready, 0);
    check("t4_done_g11v", g11_valid, 0);
    cycle();
    s_valid = 1'b0; g11_ready = 1'b0;

    // Fill queue: the fifth compute command is held
    for (int i = 0; i < 4; i++) push(1'b0, mk_cmp(11'(i + 1), 10'd1, 1'b0, 8'h00));
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_data = mk_cmp(11'd5, 10'd1, 1'b0, 8'h00);
    #1;
    check("t2_full_ready", cmd_ready, 0);
    check("t2_full_count", queue_count, 4);
    cycle();
    check("t2_held_count", queue_count, 4);
    check("t2_row_first", row_num_in, 1);
    complete_both();
    check("t2_prepop_ready", cmd_ready, 0);
    cycle();
    check("t2_after_pop", queue_count, 3);
    check("t2_ready_again", cmd_ready, 1);
    cycle();
    cmd_valid = 1'b0;
    check("t2_refill", queue_count, 4);
    check("t2_load", next_reg, 1);
    cycle(); cycle();
    complete_both();
    cycle();
    repeat (3) cycle();
    check("t6_count3", queue_count, 3);
    check("t6_busy_run", busy, 1);
    check("t6_no_err", err, 0);

    // Reset mid-RUN with three queued
    rst = 1'b0;
    cycle();
    check("t6_rst_count", queue_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", cmd_ready, 1);
    check("t6_rst_row", row_num_in, 0);
    check("t6_rst_weight", weight_num, 0);
    check("t6_rst_conv11", conv11, 0);
    check("t6_rst_pulses", {next_reg, start_cu, start_pa, layer_done}, 0);
    rst = 1'b1;
    cycle();

    // Completion pulse while IDLE
    stride_complete = 1'b1;
    cycle();
    stride_complete = 1'b0;
    check("t5_err", err, 1);
    check("t5_busy", busy, 0);
    check("t5_count", queue_count, 0);
    cycle();
    check("t5_err_sticky", err, 1);
    check("t5_still_idle", busy, 0);

    // Watchdog: 8-bit counter expires after 256 RUN cycles
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    push(1'b0, mk_cmp(11'd9, 10'd9, 1'b0, 8'h00));
    cycle(); cycle(); cycle();
    repeat (250) cycle();
    check("t7_run_busy", busy, 1);
    check("t7_no_err", err, 0);
    repeat (5) cycle();
    check("t7_edge_err", err, 0);
    cycle();
    check("t7_err", err, 1);
    check("t7_no_layer_done", layer_done, 0);
    check("t7_done_busy", busy, 1);
    cycle();
    check("t7_idle", busy, 0);
    check("t7_retired", queue_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
